memshare_coladdr_skid_buf: RTL and testbench

//  Skid buffer datapath that consumes isColAddr_skid from memShare_skid_ctrl inside SCU.memShare().
//  - Stream of column addresses passes straight through (1-cycle registered) in normal operation.
//  - While skid is asserted, the stream is delayed by one extra cycle through a holding register.
//  - After skid ends, the held word is drained with a 1-cycle upstream stall.
//  - Skid runs longer than design rule 2 allows are flagged.

---
 rtl/memshare_coladdr_skid_buf_pkg.sv | 19 +
 rtl/memshare_coladdr_skid_buf.sv | 134 +++++++++++++
 tb/tb_memshare_coladdr_skid_buf.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/memshare_coladdr_skid_buf_pkg.sv
// Shared configuration for the memShare column-address skid buffer.
//   COL_ADDR_W        : column address width
//   MAX_ALLOC_SEQ_NUM : longest legal back-to-back isGtr sequence
//   SKID_CNT_W        : width of the skid run-length counter.
//                       It must hold MAX_ALLOC_SEQ_NUM+2, its saturation value.
//   skidBuf_state_t   : skid buffer FSM states
package memShare_config_pkg;

  localparam int COL_ADDR_W        = 8;
  localparam int MAX_ALLOC_SEQ_NUM = 2;
  localparam int SKID_CNT_W        = $clog2(MAX_ALLOC_SEQ_NUM + 3);

  typedef enum logic [1:0] {
    BYPASS = 2'd0,
    SKID   = 2'd1,
    DRAIN  = 2'd2
  } skidBuf_state_t;

endpackage

// File: rtl/memshare_coladdr_skid_buf.sv
// Column-address skid buffer used inside SCU.memShare().
//
// In normal operation, column addresses pass through one output register.
// While isColAddr_skid_i is high, each word waits one extra cycle in a holding
// register. When the skid ends with a word still held, that word drains during
// a single cycle in which upstream is stalled. A skid run longer than
// MAX_ALLOC_SEQ_NUM+1 cycles sets a sticky overflow flag.
//
// Handshake: a word moves from upstream only when colAddr_vld_i and
// colAddr_rdy_o are both high in the same cycle. colAddr_rdy_o depends only on
// the FSM state, so it never depends combinationally on colAddr_vld_i.
// Downstream has no back-pressure. colAddr_vld_o marks each cycle in which
// colAddr_o carries a new word.
//
// Ports:
//   sys_clk            in   clock
//   rst                in   synchronous, active-high reset
//   colAddr_i          in   incoming column address
//   colAddr_vld_i      in   colAddr_i valid
//   colAddr_rdy_o      out  upstream ready (low only in DRAIN)
//   isColAddr_skid_i   in   skid select from memShare_skid_ctrl
//   pipeCycle_begin_i  in   start of a memShare() pipeline cycle
//                           (restarts the skid run length)
//   colAddr_o          out  registered column address; holds its value while vld is low
//   colAddr_vld_o      out  colAddr_o valid
//   skid_ovf_o         out  sticky skid-run overflow flag
//   skidState_o        out  current FSM state (debug)
module memshare_coladdr_skid_buf
  import memShare_config_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [COL_ADDR_W-1:0] colAddr_i,
  input  logic                  colAddr_vld_i,
  output logic                  colAddr_rdy_o,
  input  logic                  isColAddr_skid_i,
  input  logic                  pipeCycle_begin_i,
  output logic [COL_ADDR_W-1:0] colAddr_o,
  output logic                  colAddr_vld_o,
  output logic                  skid_ovf_o,
  output skidBuf_state_t        skidState_o
);

  localparam logic [SKID_CNT_W-1:0] CNT_ONE = SKID_CNT_W'(1);
  localparam logic [SKID_CNT_W-1:0] CNT_SAT = SKID_CNT_W'(MAX_ALLOC_SEQ_NUM + 2);

  skidBuf_state_t          state_q, state_nxt;
  logic [COL_ADDR_W-1:0]   colAddr_q, colAddr_nxt;
  logic                    vld_q, vld_nxt;
  logic [COL_ADDR_W-1:0]   skidReg_q, skidReg_nxt;
  logic                    skidVld_q, skidVld_nxt;
  logic [SKID_CNT_W-1:0]   skidCnt_q, skidCnt_nxt, skidCntInc;
  logic                    ovf_q, ovf_nxt;
  logic                    acc;

  assign colAddr_rdy_o = (state_q != DRAIN);
  assign acc           = colAddr_vld_i & colAddr_rdy_o;
  assign skidCntInc    = (skidCnt_q == CNT_SAT) ? CNT_SAT : skidCnt_q + CNT_ONE;

  always_comb begin
    state_nxt   = state_q;
    colAddr_nxt = colAddr_q;
    vld_nxt     = 1'b0;
    skidReg_nxt = skidReg_q;
    skidVld_nxt = skidVld_q;
    skidCnt_nxt = skidCnt_q;
    ovf_nxt     = ovf_q;
    unique case (state_q)
      BYPASS: begin
        if (isColAddr_skid_i) begin
          skidReg_nxt = colAddr_i;
          skidVld_nxt = acc;
          skidCnt_nxt = CNT_ONE;
          state_nxt   = SKID;
        end else begin
          vld_nxt = acc;
          // The output register loads only real words, so it holds its value across bubbles.
          if (acc) colAddr_nxt = colAddr_i;
        end
      end
      SKID: begin
        vld_nxt = skidVld_q;
        if (skidVld_q) colAddr_nxt = skidReg_q;
        skidReg_nxt = colAddr_i;
        skidVld_nxt = acc;
        if (isColAddr_skid_i) begin
          // A new pipeline cycle starts a new skid sequence. The restart takes the place of the increment.
          if (pipeCycle_begin_i) begin
            skidCnt_nxt = CNT_ONE;
          end else begin
            skidCnt_nxt = skidCntInc;
            if (skidCntInc == CNT_SAT) ovf_nxt = 1'b1;
          end
        end else begin
          skidCnt_nxt = '0;
          state_nxt   = acc ? DRAIN : BYPASS;
        end
      end
      DRAIN: begin
        vld_nxt     = 1'b1;
        colAddr_nxt = skidReg_q;
        skidVld_nxt = 1'b0;
        state_nxt   = BYPASS;
      end
      default: state_nxt = BYPASS;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= BYPASS;
      colAddr_q <= '0;
      vld_q     <= 1'b0;
      skidReg_q <= '0;
      skidVld_q <= 1'b0;
      skidCnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      colAddr_q <= colAddr_nxt;
      vld_q     <= vld_nxt;
      skidReg_q <= skidReg_nxt;
      skidVld_q <= skidVld_nxt;
      skidCnt_q <= skidCnt_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  assign colAddr_o     = colAddr_q;
  assign colAddr_vld_o = vld_q;
  assign skid_ovf_o    = ovf_q;
  assign skidState_o   = state_q;

endmodule

// File: tb/tb_memshare_coladdr_skid_buf.sv
module tb_memshare_coladdr_skid_buf;
  import memShare_config_pkg::*;

  logic                  sys_clk;
  logic                  rst;
  logic [COL_ADDR_W-1:0] colAddr_i;
  logic                  colAddr_vld_i;
  logic                  colAddr_rdy_o;
  logic                  isColAddr_skid_i;
  logic                  pipeCycle_begin_i;
  logic [COL_ADDR_W-1:0] colAddr_o;
  logic                  colAddr_vld_o;
  logic                  skid_ovf_o;
  skidBuf_state_t        skidState_o;

  int tests_run;
  int tests_failed;
  int acc_cnt;
  int out_cnt;
  logic rdy_seen;

  memshare_coladdr_skid_buf dut (
    .sys_clk           (sys_clk),
    .rst               (rst),
    .colAddr_i         (colAddr_i),
    .colAddr_vld_i     (colAddr_vld_i),
    .colAddr_rdy_o     (colAddr_rdy_o),
    .isColAddr_skid_i  (isColAddr_skid_i),
    .pipeCycle_begin_i (pipeCycle_begin_i),
    .colAddr_o         (colAddr_o),
    .colAddr_vld_o     (colAddr_vld_o),
    .skid_ovf_o        (skid_ovf_o),
    .skidState_o       (skidState_o)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then sample outputs 1 time unit after the edge
  task automatic step(input logic [7:0] addr, input logic vld, input logic skid, input logic pcb);
    colAddr_i         = addr;
    colAddr_vld_i     = vld;
    isColAddr_skid_i  = skid;
    pipeCycle_begin_i = pcb;
    rdy_seen          = colAddr_rdy_o;
    if (vld && rdy_seen) acc_cnt++;
    @(posedge sys_clk);
    #1;
    if (colAddr_vld_o) out_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    acc_cnt = 0;
    out_cnt = 0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    acc_cnt = 0;
    out_cnt = 0;
    rst = 1'b1;
    colAddr_i = '0;
    colAddr_vld_i = 1'b0;
    isColAddr_skid_i = 1'b0;
    pipeCycle_begin_i = 1'b0;

    // reset state
    do_reset();
    check("rst_vld", colAddr_vld_o, 0);
    check("rst_addr", colAddr_o, 0);
    check("rst_ovf", skid_ovf_o, 0);
    check("rst_state", skidState_o, BYPASS);
    check("rst_rdy", colAddr_rdy_o, 1);

    // 1 bypass
    step(8'h10, 1, 0, 0);
    check("byp_rdy0", rdy_seen, 1);
    check("byp_vld0", colAddr_vld_o, 1);
    check("byp_addr0", colAddr_o, 8'h10);
    step(8'h11, 1, 0, 0);
    check("byp_rdy1", rdy_seen, 1);
    check("byp_addr1", colAddr_o, 8'h11);
    step(8'h12, 1, 0, 0);
    check("byp_rdy2", rdy_seen, 1);
    check("byp_addr2", colAddr_o, 8'h12);
    step(8'h00, 0, 0, 0);
    check("byp_idle_vld", colAddr_vld_o, 0);
    check("byp_idle_hold", colAddr_o, 8'h12);

    // 2 single skid
    acc_cnt = 0;
    out_cnt = 0;
    step(8'h20, 1, 0, 0);
    check("sk_addr20", colAddr_o, 8'h20);
    check("sk_vld20", colAddr_vld_o, 1);
    step(8'h21, 1, 1, 0);
    check("sk_hold_vld", colAddr_vld_o, 0);
    check("sk_hold_addr", colAddr_o, 8'h20);
    check("sk_state_skid", skidState_o, SKID);
    step(8'h22, 1, 0, 0);
    check("sk_addr21", colAddr_o, 8'h21);
    check("sk_vld21", colAddr_vld_o, 1);
    check("sk_state_drain", skidState_o, DRAIN);
    check("sk_rdy_drain", colAddr_rdy_o, 0);
    step(8'h23, 1, 0, 0);  // not accepted: DRAIN stalls upstream
    check("sk_addr22", colAddr_o, 8'h22);
    check("sk_vld22", colAddr_vld_o, 1);
    check("sk_state_byp", skidState_o, BYPASS);
    step(8'h23, 1, 0, 0);
    check("sk_rdy_back", rdy_seen, 1);
    check("sk_addr23", colAddr_o, 8'h23);
    step(8'h00, 0, 0, 0);
    check("sk_idle_vld", colAddr_vld_o, 0);
    check("sk_acc_cnt", acc_cnt, 4);
    check("sk_out_cnt", out_cnt, 4);

    // 3 max run: 3 cycles of skid do not overflow
    do_reset();
    step(8'h30, 1, 1, 0);
    step(8'h31, 1, 1, 0);
    step(8'h32, 1, 1, 0);
    check("run3_ovf", skid_ovf_o, 0);
    step(8'h33, 1, 0, 0);
    check("run3_addr32", colAddr_o, 8'h32);
    check("run3_ovf_b", skid_ovf_o, 0);
    step(8'h34, 1, 0, 0);  // DRAIN, 0x34 refused
    check("run3_drain_addr", colAddr_o, 8'h33);
    step(8'h34, 1, 0, 0);
    check("run3_addr34", colAddr_o, 8'h34);
    check("run3_ovf_c", skid_ovf_o, 0);
    // 4 cycles of skid overflow at the 4th edge
    step(8'h40, 1, 1, 0);
    step(8'h41, 1, 1, 0);
    step(8'h42, 1, 1, 0);
    check("run4_ovf_e3", skid_ovf_o, 0);
    step(8'h43, 1, 1, 0);
    check("run4_ovf_e4", skid_ovf_o, 1);
    step(8'h44, 1, 0, 0);
    step(8'h45, 1, 0, 0);
    step(8'h45, 1, 0, 0);
    step(8'h00, 0, 0, 0);
    check("run4_ovf_sticky", skid_ovf_o, 1);
    do_reset();
    check("run4_ovf_rst", skid_ovf_o, 0);

    // 4 pipeCycle_begin restarts the run
    step(8'h60, 1, 1, 0);
    step(8'h61, 1, 1, 0);
    step(8'h62, 1, 1, 1);
    step(8'h63, 1, 1, 0);
    check("pcb_ovf", skid_ovf_o, 0);
    step(8'h64, 0, 0, 0);
    check("pcb_ovf_b", skid_ovf_o, 0);
    step(8'h00, 0, 0, 0);
    step(8'h00, 0, 0, 0);

    // 5 skid ends with a bubble: SKID -> BYPASS, no DRAIN
    do_reset();
    step(8'h50, 1, 1, 0);
    check("bub_state_skid", skidState_o, SKID);
    step(8'h51, 0, 0, 0);
    check("bub_addr50", colAddr_o, 8'h50);
    check("bub_vld50", colAddr_vld_o, 1);
    check("bub_state_byp", skidState_o, BYPASS);
    check("bub_rdy", colAddr_rdy_o, 1);
    step(8'h52, 1, 0, 0);
    check("bub_rdy_b", rdy_seen, 1);
    check("bub_addr52", colAddr_o, 8'h52);

    // 6 reset while SKID is holding 0x55
    step(8'h55, 1, 1, 0);
    check("rstmid_state", skidState_o, SKID);
    rst = 1'b1;
    step(8'h00, 0, 0, 0);
    rst = 1'b0;
    check("rstmid_vld", colAddr_vld_o, 0);
    check("rstmid_addr", colAddr_o, 0);
    check("rstmid_state_byp", skidState_o, BYPASS);
    out_cnt = 0;
    step(8'h00, 0, 0, 0);
    step(8'h00, 0, 0, 0);
    check("rstmid_no55", out_cnt, 0);
    check("rstmid_addr_b", colAddr_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
